// File: rtl/hht_pkg.sv
// Shared types and default widths for the HHT CSR fetch front-end.
// The beat struct is the default FIFO payload; wider or narrower builds use a local struct.
package hht_pkg;

   localparam int unsigned HHT_DW         = 32;
   localparam int unsigned HHT_AW         = 32;
   localparam int unsigned HHT_RW         = 16;
   localparam int unsigned HHT_FIFO_DEPTH = 4;

   typedef logic [2:0] hht_fetch_state_t;

   localparam hht_fetch_state_t StIdle   = 3'd0;
   localparam hht_fetch_state_t StPtr0   = 3'd1;
   localparam hht_fetch_state_t StPtr    = 3'd2;
   localparam hht_fetch_state_t StFetch  = 3'd3;
   localparam hht_fetch_state_t StGather = 3'd4;
   localparam hht_fetch_state_t StDone   = 3'd5;

   typedef struct packed {
      logic [HHT_RW-1:0] row;
      logic [HHT_DW-1:0] mval;
      logic [HHT_DW-1:0] vval;
      logic              last;
   } hht_beat_t;

endpackage

// File: rtl/hht_csr_fetch_if.sv
// Bus bundle of the CSR fetch block: start/config, two memory read ports, beat stream, status.
interface hht_csr_fetch_if #(
   parameter int unsigned DW = hht_pkg::HHT_DW,
   parameter int unsigned AW = hht_pkg::HHT_AW,
   parameter int unsigned RW = hht_pkg::HHT_RW
);
   logic          start;
   logic [RW-1:0] num_rows;
   logic [AW-1:0] row_base;
   logic [AW-1:0] col_base;
   logic [AW-1:0] matrix_base;
   logic [AW-1:0] v_values_base;
   logic [AW-1:0] addr1;
   logic [DW-1:0] dataIn1;
   logic [AW-1:0] addr2;
   logic [DW-1:0] dataIn2;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic [DW-1:0] out_mval;
   logic [DW-1:0] out_vval;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, num_rows, row_base, col_base, matrix_base, v_values_base,
      output dataIn1, dataIn2, out_ready,
      input  addr1, addr2, out_valid, out_row, out_mval, out_vval, out_last, busy, done, err
   );

   modport slave (
      input  start, num_rows, row_base, col_base, matrix_base, v_values_base,
      input  dataIn1, dataIn2, out_ready,
      output addr1, addr2, out_valid, out_row, out_mval, out_vval, out_last, busy, done, err
   );
endinterface

// File: rtl/hht_sync_fifo.sv
// Synchronous FIFO with registered storage; head reads as zero while empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module hht_sync_fifo
   import hht_pkg::*;
#(
   parameter type         T     = hht_beat_t,
   parameter int unsigned Depth = HHT_FIFO_DEPTH
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     wdata_i,
   input  logic pop_i,
   output T     rdata_o,
   output logic full_o,
   output logic empty_o
);
   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = PW + 1;

   T              mem_q [Depth];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(Depth));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + PW'(1);
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/hht_csr_fetch.sv
// CSR walker: reads row pointers, then per non-zero the column/value pair and the gathered
// vector entry, emitting one beat per non-zero (one zero beat per empty row) into a FIFO.
module hht_csr_fetch
   import hht_pkg::*;
#(
   parameter int unsigned DW         = HHT_DW,
   parameter int unsigned AW         = HHT_AW,
   parameter int unsigned RW         = HHT_RW,
   parameter int unsigned FIFO_DEPTH = HHT_FIFO_DEPTH
) (
   input  logic           Clk,
   input  logic           Rst,
   hht_csr_fetch_if.slave bus_io
);
   localparam int unsigned RW1 = RW + 1;

   typedef struct packed {
      logic [RW-1:0] row;
      logic [DW-1:0] mval;
      logic [DW-1:0] vval;
      logic          last;
   } beat_t;

   hht_fetch_state_t state_q, state_d;
   logic [RW-1:0]    r_q, r_d, nrows_q;
   logic [AW-1:0]    k_q, k_d, kend_q, kend_d, col_q, col_d;
   logic [DW-1:0]    mval_q, mval_d;
   logic [AW-1:0]    row_base_q, col_base_q, mat_base_q, vec_base_q;
   logic             err_q, err_d;
   logic             cfg_ld, push, adv, can_push, fifo_full, fifo_empty, beat_last, row_last;
   logic [AW-1:0]    ptr, addr1, addr2;
   beat_t            wbeat, rbeat;

   // Pointer and column words are reinterpreted as addresses of width AW.
   assign ptr       = AW'(bus_io.dataIn1);
   assign can_push  = !fifo_full || bus_io.out_ready;
   assign beat_last = (k_q + AW'(1)) == kend_q;
   assign row_last  = ({1'b0, r_q} + RW1'(1)) == {1'b0, nrows_q};

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      k_d     = k_q;
      kend_d  = kend_q;
      col_d   = col_q;
      mval_d  = mval_q;
      err_d   = err_q;
      addr1   = '0;
      addr2   = '0;
      push    = 1'b0;
      wbeat   = '0;
      cfg_ld  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               cfg_ld  = 1'b1;
               r_d     = '0;
               err_d   = 1'b0;
               state_d = (bus_io.num_rows == '0) ? StDone : StPtr0;
            end
         end
         StPtr0: begin
            addr1   = row_base_q;
            k_d     = ptr;
            state_d = StPtr;
         end
         StPtr: begin
            addr1  = row_base_q + AW'(r_q) + AW'(1);
            kend_d = ptr;
            if (ptr > k_q) begin
               state_d = StFetch;
            end else if (can_push) begin
               // Empty or regressing row: k is kept so later rows still start at the true end.
               push       = 1'b1;
               wbeat.row  = r_q;
               wbeat.last = 1'b1;
               if (ptr < k_q) err_d = 1'b1;
               adv = 1'b1;
            end
         end
         StFetch: begin
            addr1   = col_base_q + k_q;
            addr2   = mat_base_q + k_q;
            col_d   = ptr;
            mval_d  = bus_io.dataIn2;
            state_d = StGather;
         end
         StGather: begin
            addr2 = vec_base_q + col_q;
            if (can_push) begin
               push       = 1'b1;
               wbeat.row  = r_q;
               wbeat.mval = mval_q;
               wbeat.vval = bus_io.dataIn2;
               wbeat.last = beat_last;
               k_d        = k_q + AW'(1);
               if (beat_last) adv = 1'b1;
               else state_d = StFetch;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (adv) begin
         if (row_last) begin
            state_d = StDone;
         end else begin
            r_d     = r_q + RW'(1);
            state_d = StPtr;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= StIdle;
         r_q        <= '0;
         k_q        <= '0;
         kend_q     <= '0;
         col_q      <= '0;
         mval_q     <= '0;
         err_q      <= 1'b0;
         nrows_q    <= '0;
         row_base_q <= '0;
         col_base_q <= '0;
         mat_base_q <= '0;
         vec_base_q <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         k_q     <= k_d;
         kend_q  <= kend_d;
         col_q   <= col_d;
         mval_q  <= mval_d;
         err_q   <= err_d;
         if (cfg_ld) begin
            nrows_q    <= bus_io.num_rows;
            row_base_q <= bus_io.row_base;
            col_base_q <= bus_io.col_base;
            mat_base_q <= bus_io.matrix_base;
            vec_base_q <= bus_io.v_values_base;
         end
      end
   end

   hht_sync_fifo #(
      .T     (beat_t),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Rst),
      .push_i  (push),
      .wdata_i (wbeat),
      .pop_i   (bus_io.out_ready),
      .rdata_o (rbeat),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus_io.addr1     = addr1;
   assign bus_io.addr2     = addr2;
   assign bus_io.out_valid = !fifo_empty;
   assign bus_io.out_row   = rbeat.row;
   assign bus_io.out_mval  = rbeat.mval;
   assign bus_io.out_vval  = rbeat.vval;
   assign bus_io.out_last  = rbeat.last;
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.done      = (state_q == StDone);
   assign bus_io.err       = err_q;

endmodule

// File: tb/tb_hht_csr_fetch.sv
// Bench for hht_csr_fetch: table of walk configurations, random CSR walks with random
// back-pressure checked against a row-by-row reference model, plus stall and reset sequences.
module tb_hht_csr_fetch;
   localparam int unsigned DW = 32, AW = 32, RW = 16, DEPTH = 4;
   localparam int unsigned RB = 14610, CB = 1410, MB = 90, VB = 2;

   typedef struct packed {
      logic [RW-1:0] row;
      logic [DW-1:0] mval;
      logic [DW-1:0] vval;
      logic          last;
   } tb_beat_t;

   typedef struct {
      int nrows;
      bit dense;
      int rp[4];
      int mode;
      int exp_beats;
      bit exp_err;
      int exp_first;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hht_csr_fetch_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

   hht_csr_fetch #(.DW(DW), .AW(AW), .RW(RW), .FIFO_DEPTH(DEPTH)) dut (
      .Clk    (clk),
      .Rst    (rst_n),
      .bus_io (bus)
   );

   logic [31:0] mem [0:16383];
   assign bus.dataIn1 = (bus.addr1 < 32'd16384) ? mem[bus.addr1[13:0]] : '0;
   assign bus.dataIn2 = (bus.addr2 < 32'd16384) ? mem[bus.addr2[13:0]] : '0;

   int unsigned rp_a [0:16];
   int unsigned ci_a [0:63];
   int unsigned mv_a [0:63];
   int unsigned vv_a [0:63];
   tb_beat_t    exp_q [$];
   tb_beat_t    got_q [$];
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic load_dense();
      rp_a[0] = 0; rp_a[1] = 4; rp_a[2] = 6;
      for (int r = 2; r < 16; r++) begin
         rp_a[r+1] = rp_a[r] + (((r % 2) == 0 || r == 15) ? 3 : 4);
      end
      for (int i = 0; i < 64; i++) begin
         ci_a[i] = (i * 7 + 3) % 64;
         mv_a[i] = $urandom_range(1, 1000);
         vv_a[i] = $urandom;
      end
      ci_a[0] = 0;  ci_a[1] = 8;  ci_a[2] = 9;  ci_a[3] = 14;
      mv_a[0] = 30; mv_a[1] = 25; mv_a[2] = 89; mv_a[3] = 98;
      vv_a[0] = 6;  vv_a[8] = 96; vv_a[9] = 71; vv_a[14] = 90;
   endtask

   task automatic write_mem();
      for (int i = 0; i < 17; i++) mem[RB+i] = rp_a[i];
      for (int i = 0; i < 64; i++) begin
         mem[CB+i] = ci_a[i];
         mem[MB+i] = mv_a[i];
         mem[VB+i] = vv_a[i];
      end
   endtask

   // Row-by-row CSR semantics: a row spans [k, rp[r+1]); a non-advancing pointer is an empty row.
   function automatic bit model(input int nrows);
      int k, e;
      bit er;
      tb_beat_t b;
      exp_q.delete();
      er = 1'b0;
      if (nrows == 0) return 1'b0;
      k = int'(rp_a[0]);
      for (int r = 0; r < nrows; r++) begin
         e = int'(rp_a[r+1]);
         if (e > k) begin
            for (int j = k; j < e; j++) begin
               b.row  = 16'(r);
               b.mval = mv_a[j];
               b.vval = vv_a[ci_a[j]];
               b.last = (j == e - 1);
               exp_q.push_back(b);
            end
            k = e;
         end else begin
            b = '0;
            b.row  = 16'(r);
            b.last = 1'b1;
            exp_q.push_back(b);
            if (e < k) er = 1'b1;
         end
      end
      return er;
   endfunction

   task automatic start_walk(input int nrows);
      @(negedge clk);
      bus.num_rows      = 16'(nrows);
      bus.row_base      = RB;
      bus.col_base      = CB;
      bus.matrix_base   = MB;
      bus.v_values_base = VB;
      bus.start         = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", 128'(bus.busy), 128'(1));
      check("err_cleared_on_start", 128'(bus.err), 128'(0));
   endtask

   // Entered at the negedge of cycle T+1; consumes beats until done has passed and FIFO is empty.
   task automatic collect(input int mode, output int first_valid, output int ndone,
                          output int nbeats);
      int       cyc, n0;
      bit       done_seen, pv, pr, rdy;
      tb_beat_t pb, cur;
      cyc = 1; n0 = exp_q.size(); done_seen = 0; pv = 0; pr = 0; pb = '0;
      first_valid = 0; ndone = 0; nbeats = 0;
      got_q.delete();
      while (1) begin
         rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         cur = {bus.out_row, bus.out_mval, bus.out_vval, bus.out_last};
         if (pv && !pr) begin
            check("hold_valid", 128'(bus.out_valid), 128'(1));
            check("hold_data", 128'(cur), 128'(pb));
         end
         if (bus.out_valid && first_valid == 0) first_valid = cyc;
         if (bus.done) begin
            ndone++;
            done_seen = 1;
            if (mode == 0 && n0 > 0) check("done_after_last_push", 128'(exp_q.size()), 128'(1));
         end
         if (bus.out_valid && rdy) begin
            nbeats++;
            got_q.push_back(cur);
            if (exp_q.size() == 0) check("beat_overflow", 128'(nbeats), 128'(n0));
            else check("beat", 128'(cur), 128'(exp_q.pop_front()));
         end
         pv = bus.out_valid; pr = rdy; pb = cur;
         if (done_seen && !bus.out_valid) break;
         if (cyc >= 3000) begin
            check("walk_timeout", 128'(cyc), 128'(0));
            break;
         end
         @(negedge clk);
         cyc++;
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic add_vec(input int i, input int n, input bit d, input int r0, input int r1,
                          input int r2, input int r3, input int m, input int nb, input bit e,
                          input int f);
      vecs[i].nrows = n; vecs[i].dense = d;
      vecs[i].rp[0] = r0; vecs[i].rp[1] = r1; vecs[i].rp[2] = r2; vecs[i].rp[3] = r3;
      vecs[i].mode = m; vecs[i].exp_beats = nb; vecs[i].exp_err = e; vecs[i].exp_first = f;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fv, nd, nb, nexp;
      bit me;
      logic [AW-1:0] a1, a2;
      tb_beat_t lit [4];

      add_vec(0, 1,  1, 0, 0, 0, 0, 0, 4,  0, 5);
      add_vec(1, 16, 1, 0, 0, 0, 0, 0, 54, 0, 5);
      add_vec(2, 3,  0, 0, 2, 2, 3, 0, 4,  0, 5);
      add_vec(3, 2,  0, 0, 3, 1, 0, 0, 4,  1, 5);
      add_vec(4, 16, 1, 0, 0, 0, 0, 1, 54, 0, 5);
      add_vec(5, 0,  1, 0, 0, 0, 0, 0, 0,  0, 0);
      lit[0] = {16'd0, 32'd30, 32'd6,  1'b0};
      lit[1] = {16'd0, 32'd25, 32'd96, 1'b0};
      lit[2] = {16'd0, 32'd89, 32'd71, 1'b0};
      lit[3] = {16'd0, 32'd98, 32'd90, 1'b1};

      for (int i = 0; i < 16384; i++) mem[i] = '0;
      bus.start = 0; bus.num_rows = 0; bus.row_base = 0; bus.col_base = 0;
      bus.matrix_base = 0; bus.v_values_base = 0; bus.out_ready = 1;

      repeat (3) @(negedge clk);
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_done", 128'(bus.done), 128'(0));
      check("rst_err", 128'(bus.err), 128'(0));
      check("rst_valid", 128'(bus.out_valid), 128'(0));
      check("rst_addrs", 128'({bus.addr1, bus.addr2}), 128'(0));
      check("rst_data", 128'({bus.out_row, bus.out_mval, bus.out_vval, bus.out_last}), 128'(0));
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) begin
         load_dense();
         if (!vecs[t].dense) for (int i = 0; i < 4; i++) rp_a[i] = vecs[t].rp[i];
         write_mem();
         me = model(vecs[t].nrows);
         start_walk(vecs[t].nrows);
         collect(vecs[t].mode, fv, nd, nb);
         check($sformatf("v%0d_beats", t), 128'(nb), 128'(vecs[t].exp_beats));
         check($sformatf("v%0d_first_valid", t), 128'(fv), 128'(vecs[t].exp_first));
         check($sformatf("v%0d_done_once", t), 128'(nd), 128'(1));
         check($sformatf("v%0d_err", t), 128'(bus.err), 128'(vecs[t].exp_err));
         check($sformatf("v%0d_model_err", t), 128'(bus.err), 128'(me));
         if (t == 0) begin
            check("dense1_count", 128'(got_q.size()), 128'(4));
            for (int i = 0; i < 4 && i < got_q.size(); i++)
               check($sformatf("dense1_beat%0d", i), 128'(got_q[i]), 128'(lit[i]));
         end
         repeat (5) @(negedge clk);
         check($sformatf("v%0d_busy_low", t), 128'(bus.busy), 128'(0));
         check($sformatf("v%0d_err_sticky", t), 128'(bus.err), 128'(vecs[t].exp_err));
      end

      // Random CSR structures, including regressing pointers, with random back-pressure.
      for (int t = 0; t < 8; t++) begin
         int n, cur;
         load_dense();
         n = $urandom_range(1, 8);
         rp_a[0] = $urandom_range(0, 2);
         cur = int'(rp_a[0]);
         for (int r = 1; r <= n; r++) begin
            if ($urandom_range(0, 6) == 0 && cur > 0) rp_a[r] = $urandom_range(0, cur - 1);
            else rp_a[r] = cur + $urandom_range(0, 4);
            cur = int'(rp_a[r]);
         end
         write_mem();
         me = model(n);
         nexp = exp_q.size();
         start_walk(n);
         collect(1, fv, nd, nb);
         check($sformatf("rnd%0d_beats", t), 128'(nb), 128'(nexp));
         check($sformatf("rnd%0d_err", t), 128'(bus.err), 128'(me));
         check($sformatf("rnd%0d_done_once", t), 128'(nd), 128'(1));
         repeat (2) @(negedge clk);
      end

      // Downstream stalled for 20 cycles: four beats buffered, walker parked on the 5th gather.
      load_dense();
      write_mem();
      me = model(16);
      bus.out_ready = 1'b0;
      start_walk(16);
      a1 = '0; a2 = '0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 18) begin a1 = bus.addr1; a2 = bus.addr2; end
         if (c == 20) begin
            check("stall_addr2", 128'(bus.addr2), 128'(VB + ci_a[4]));
            check("stall_addr2_stable", 128'(bus.addr2), 128'(a2));
            check("stall_addr1_stable", 128'(bus.addr1), 128'(a1));
            check("stall_valid", 128'(bus.out_valid), 128'(1));
            check("stall_busy", 128'(bus.busy), 128'(1));
            check("stall_head", 128'({bus.out_row, bus.out_mval, bus.out_vval, bus.out_last}),
                  128'(exp_q[0]));
         end else begin
            @(negedge clk);
         end
      end
      collect(0, fv, nd, nb);
      check("stall_total_beats", 128'(nb), 128'(54));
      check("stall_queue_drained", 128'(exp_q.size()), 128'(0));
      repeat (3) @(negedge clk);

      // Reset in the middle of a gather with one beat buffered.
      load_dense();
      write_mem();
      bus.out_ready = 1'b0;
      start_walk(16);
      repeat (5) @(negedge clk);
      check("pre_rst_addr2", 128'(bus.addr2), 128'(VB + ci_a[1]));
      check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
      check("mid_rst_busy", 128'(bus.busy), 128'(0));
      check("mid_rst_addrs", 128'({bus.addr1, bus.addr2}), 128'(0));
      check("mid_rst_data", 128'({bus.out_row, bus.out_mval, bus.out_vval, bus.out_last}),
            128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      me = model(1);
      start_walk(1);
      collect(0, fv, nd, nb);
      check("restart_beats", 128'(nb), 128'(4));
      check("restart_first_valid", 128'(fv), 128'(5));
      check("restart_done_once", 128'(nd), 128'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
